// File: rtl/xyz_datapath.sv
// X/Y/Z register datapath with add/subtract ULA, driven by per-cycle decoder codes.
// Optional sticky signed-overflow output ovf when XYZ_DATAPATH_OVF_EN is defined.
module xyz_datapath #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       tX,
    input  logic [2:0]       tY,
    input  logic [1:0]       tZ,
    input  logic             tULA,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic [WIDTH-1:0] z_out,
    output logic [WIDTH-1:0] ula_out,
    output logic             carry,
    output logic             zero,
    output logic             cmd_ack
`ifdef XYZ_DATAPATH_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [1:0] XZ_CLEAR = 2'b00;
    localparam logic [1:0] XZ_LOAD  = 2'b01;

    localparam logic [2:0] Y_CLEAR = 3'b000;
    localparam logic [2:0] Y_LOAD  = 3'b001;
    localparam logic [2:0] Y_SL    = 3'b011;
    localparam logic [2:0] Y_SR    = 3'b100;

    logic [WIDTH-1:0] x_r, y_r, z_r;
    logic [WIDTH-1:0] x_nxt, y_nxt, z_nxt;
    logic [WIDTH:0]   ula_full;
    logic             carry_r, carry_nxt;
    logic             zero_r;
    logic             ack_r;

    // Bit WIDTH of the extended result is carry for ADD and borrow for SUB.
    always_comb begin
        if (tULA) begin
            ula_full = {1'b0, y_r} - {1'b0, x_r};
        end else begin
            ula_full = {1'b0, y_r} + {1'b0, x_r};
        end
    end

    assign ula_out = ula_full[WIDTH-1:0];

    always_comb begin
        x_nxt     = x_r;
        y_nxt     = y_r;
        z_nxt     = z_r;
        carry_nxt = carry_r;
        if (cmd_valid) begin
            case (tX)
                XZ_CLEAR: x_nxt = '0;
                XZ_LOAD:  x_nxt = data_in;
                default:  x_nxt = x_r;
            endcase
            case (tY)
                Y_CLEAR: begin
                    y_nxt     = '0;
                    carry_nxt = 1'b0;
                end
                Y_LOAD: begin
                    y_nxt     = ula_full[WIDTH-1:0];
                    carry_nxt = ula_full[WIDTH];
                end
                Y_SL:    y_nxt = {y_r[WIDTH-2:0], 1'b0};
                Y_SR:    y_nxt = {1'b0, y_r[WIDTH-1:1]};
                default: y_nxt = y_r;
            endcase
            // Z samples the pre-edge Y, never the value written this cycle.
            case (tZ)
                XZ_CLEAR: z_nxt = '0;
                XZ_LOAD:  z_nxt = y_r;
                default:  z_nxt = z_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            carry_r <= 1'b0;
            zero_r  <= 1'b1;
            ack_r   <= 1'b0;
        end else begin
            x_r     <= x_nxt;
            y_r     <= y_nxt;
            z_r     <= z_nxt;
            carry_r <= carry_nxt;
            zero_r  <= (y_nxt == '0);
            ack_r   <= cmd_valid;
        end
    end

    assign x_out   = x_r;
    assign y_out   = y_r;
    assign z_out   = z_r;
    assign carry   = carry_r;
    assign zero    = zero_r;
    assign cmd_ack = ack_r;

`ifdef XYZ_DATAPATH_OVF_EN
    logic ovf_r;
    logic ovf_calc;

    // Signed overflow: operand signs agree (ADD) or differ (SUB) and the result sign flips.
    always_comb begin
        if (tULA) begin
            ovf_calc = (y_r[WIDTH-1] != x_r[WIDTH-1]) && (ula_full[WIDTH-1] != y_r[WIDTH-1]);
        end else begin
            ovf_calc = (y_r[WIDTH-1] == x_r[WIDTH-1]) && (ula_full[WIDTH-1] != y_r[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (cmd_valid && (tY == Y_CLEAR)) begin
            ovf_r <= 1'b0;
        end else if (cmd_valid && (tY == Y_LOAD) && ovf_calc) begin
            ovf_r <= 1'b1;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule
